cache_rd_dm: RTL and testbench

CACHE_RD_DM -- requirements
Module: cache_rd_dm

---
 rtl/cache_rd_dm.sv | 157 +++++++++++++++
 tb/tb_cache_rd_dm.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_rd_dm.sv
// Direct-mapped read-only cache that refills whole lines from a PSRAM controller.
// Define CACHE_RD_DM_STATS_EN to add the hit_count/miss_count outputs.
module cache_rd_dm #(
    parameter int ADDR_W = 32,
    parameter int IX_W   = 6,
    parameter int OFS_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] address,
    output logic              rsp_valid,
`ifdef CACHE_RD_DM_STATS_EN
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
`endif
    output logic [31:0]       data_out,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);
    localparam int TAG_W = ADDR_W - IX_W - OFS_W - 2;
    localparam int LINES = 1 << IX_W;
    localparam int WORDS = 1 << (IX_W + OFS_W);

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_FILL, S_DONE} state_t;

    state_t                r_state;
    logic [ADDR_W-3:0]     r_waddr;
    logic [LINES-1:0]      r_valid;
    logic [TAG_W-1:0]      r_tag_mem [LINES];
    logic [31:0]           r_data_mem [WORDS];
    logic [TAG_W-1:0]      r_rd_tag;
    logic [31:0]           r_rd_data;
    logic [31:0]           r_fill_word;
    logic [31:0]           r_data_out;
    logic [OFS_W-1:0]      r_cnt;
    logic                  r_mem_req;
    logic [ADDR_W-1:0]     r_mem_addr;

    logic [TAG_W-1:0]      w_tag;
    logic [IX_W-1:0]       w_idx;
    logic [OFS_W-1:0]      w_word;
    logic [IX_W-1:0]       w_in_idx;
    logic [IX_W+OFS_W-1:0] w_in_ixw;
    logic                  w_accept;
    logic                  w_hit;
    logic                  w_last;
    logic                  w_fill_we;
    logic                  w_rsp;
    logic [31:0]           w_rsp_data;
    logic                  w_unused;

    assign w_tag      = r_waddr[ADDR_W-3:IX_W+OFS_W];
    assign w_idx      = r_waddr[IX_W+OFS_W-1:OFS_W];
    assign w_word     = r_waddr[OFS_W-1:0];
    assign w_in_idx   = address[IX_W+OFS_W+1:OFS_W+2];
    assign w_in_ixw   = address[IX_W+OFS_W+1:2];
    assign w_unused   = ^address[1:0];

    assign w_accept   = req_valid && (r_state == S_IDLE);
    assign w_hit      = r_valid[w_idx] && (r_rd_tag == w_tag);
    assign w_last     = &r_cnt;
    assign w_fill_we  = (r_state == S_FILL) && mem_rvalid && !rst;
    assign w_rsp      = ((r_state == S_LOOKUP) && w_hit) || (r_state == S_DONE);
    assign w_rsp_data = (r_state == S_DONE) ? r_fill_word : r_rd_data;

    assign req_ready  = (r_state == S_IDLE);
    assign rsp_valid  = w_rsp;
    assign data_out   = w_rsp ? w_rsp_data : r_data_out;
    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;

    // Tag/data RAMs: read on the accepting edge so LOOKUP sees them, never reset
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_rd_tag  <= r_tag_mem[w_in_idx];
            r_rd_data <= r_data_mem[w_in_ixw];
        end
        if (w_fill_we) begin
            r_data_mem[{w_idx, r_cnt}] <= mem_rdata;
            if (w_last)
                r_tag_mem[w_idx] <= w_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_waddr     <= '0;
            r_valid     <= '0;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_fill_word <= '0;
            r_data_out  <= '0;
        end else begin
            if (w_rsp)
                r_data_out <= w_rsp_data;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_waddr <= address[ADDR_W-1:2];
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state    <= S_FILL;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= {r_waddr[ADDR_W-3:OFS_W], {(OFS_W+2){1'b0}}};
                        r_cnt      <= '0;
                    end
                end
                S_FILL: begin
                    if (mem_rvalid) begin
                        r_mem_req <= 1'b0;
                        r_cnt     <= r_cnt + 1'b1;
                        // Capture the requested word as it streams past; DONE answers from here
                        if (r_cnt == w_word)
                            r_fill_word <= mem_rdata;
                        if (w_last) begin
                            r_valid[w_idx] <= 1'b1;
                            r_state        <= S_DONE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef CACHE_RD_DM_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (r_state == S_LOOKUP) begin
            if (w_hit)
                r_hit_count <= r_hit_count + 32'd1;
            else
                r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif
endmodule

// File: tb/tb_cache_rd_dm.sv
// Bench for cache_rd_dm: PSRAM responder, line-level cache model and per-cycle output checks.
module tb_cache_rd_dm;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] address;
    logic        rsp_valid;
    logic [31:0] data_out;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
`ifdef CACHE_RD_DM_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    cache_rd_dm dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .address    (address),
        .rsp_valid  (rsp_valid),
`ifdef CACHE_RD_DM_STATS_EN
        .hit_count  (hit_count),
        .miss_count (miss_count),
`endif
        .data_out   (data_out),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Cache model: per line a valid bit, the tag (addr >> 11) and 8 words
    bit          m_valid [64];
    int unsigned m_tag   [64];
    logic [31:0] m_data  [64][8];

    bit          chk_en = 1'b0;
    logic        exp_rsp, exp_mreq, exp_ready;
    logic [31:0] exp_data, exp_maddr;
    logic [31:0] got_data;
    bit          got_hit;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] line, input int w);
        return (line ^ 32'h100) + 32'(w);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
            check("data_out",  data_out, exp_data);
            check("mem_req",   32'(mem_req), 32'(exp_mreq));
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            if (exp_mreq)
                check("mem_addr", mem_addr, exp_maddr);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic stray_rvalid();
        mem_rvalid = 1'($urandom_range(1, 0));
        mem_rdata  = $urandom;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    endtask

    // One read; abort_at >= 0 pulses rst after that many fill words
    task automatic do_read(input logic [31:0] addr, input int gmin, input int gmax, input int abort_at);
        int unsigned tag;
        int          idx, wd;
        logic [31:0] line;
        bit          hit;
        tag  = addr >> 11;
        idx  = int'((addr >> 5) & 32'h3f);
        wd   = int'((addr >> 2) & 32'h7);
        line = addr & ~32'h1f;
        hit  = m_valid[idx] && (m_tag[idx] == tag);
        got_hit  = hit;
        got_data = 32'hdead_beef;
        req_valid = 1'b1;
        address   = addr;
        cyc();
        req_valid = 1'b0;
        address   = $urandom;
        exp_ready = 1'b0;
        stray_rvalid();
        if (hit) begin
            exp_rsp  = 1'b1;
            exp_data = m_data[idx][wd];
            @(negedge clk);
            got_data = data_out;
            cyc();
            mem_rvalid = 1'b0;
            exp_rsp    = 1'b0;
            exp_ready  = 1'b1;
            return;
        end
        cyc();
        mem_rvalid = 1'b0;
        exp_mreq   = 1'b1;
        exp_maddr  = line;
        for (int w = 0; w < 8; w++) begin
            if (w == abort_at) begin
                chk_en = 1'b0;
                rst    = 1'b1;
                cyc();
                rst       = 1'b0;
                model_reset();
                exp_mreq  = 1'b0;
                exp_rsp   = 1'b0;
                exp_ready = 1'b1;
                exp_data  = 32'h0;
                chk_en    = 1'b1;
                return;
            end
            repeat ($urandom_range(gmax, gmin)) cyc();
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(line, w);
            cyc();
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            exp_mreq   = 1'b0;
        end
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tag;
        for (int w = 0; w < 8; w++) m_data[idx][w] = mem_word(line, w);
        exp_rsp  = 1'b1;
        exp_data = m_data[idx][wd];
        stray_rvalid();
        @(negedge clk);
        got_data = data_out;
        cyc();
        mem_rvalid = 1'b0;
        exp_rsp    = 1'b0;
        exp_ready  = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            stray_rvalid();
            cyc();
            mem_rvalid = 1'b0;
        end
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        address    = '0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        exp_rsp    = 1'b0;
        exp_mreq   = 1'b0;
        exp_ready  = 1'b1;
        exp_data   = '0;
        exp_maddr  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mem_req",   32'(mem_req), 32'd0);
        check("rst_mem_addr",  mem_addr, 32'd0);
        check("rst_data_out",  data_out, 32'd0);
        cyc();
        chk_en = 1'b1;

        do_read(32'h0000_0004, 0, 1, -1);
        check("cold_hit",  32'(got_hit), 32'd0);
        check("cold_data", got_data, 32'h101);
        idle_cycles(2);
        do_read(32'h0000_001C, 0, 0, -1);
        check("warm_hit",  32'(got_hit), 32'd1);
        check("warm_data", got_data, 32'h107);
        do_read(32'h0000_0800, 0, 2, -1);
        check("alias_hit",  32'(got_hit), 32'd0);
        check("alias_data", got_data, 32'h900);
        do_read(32'h0000_0004, 0, 2, -1);
        check("evict_hit",  32'(got_hit), 32'd0);
        check("evict_data", got_data, 32'h101);
`ifdef CACHE_RD_DM_STATS_EN
        check("hit_count",  hit_count, 32'd1);
        check("miss_count", miss_count, 32'd3);
`endif
        do_read(32'h0000_0040, 3, 3, -1);
        check("gap_hit",  32'(got_hit), 32'd0);
        check("gap_data", got_data, 32'h140);
        do_read(32'h0000_005C, 0, 0, -1);
        check("gap_line_hit",  32'(got_hit), 32'd1);
        check("gap_line_data", got_data, 32'h147);

        do_read(32'h0000_0064, 0, 2, 4);
        idle_cycles(2);
        do_read(32'h0000_0064, 0, 2, -1);
        check("abort_refill_hit",  32'(got_hit), 32'd0);
        check("abort_refill_data", got_data, 32'h161);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = ($urandom_range(3, 0) << 11) | ($urandom_range(3, 0) << 5) |
                ($urandom_range(7, 0) << 2) | $urandom_range(3, 0);
            if ($urandom_range(24, 0) == 0)
                do_read(a, 0, 3, int'($urandom_range(7, 0)));
            else
                do_read(a, 0, 3, -1);
            idle_cycles(int'($urandom_range(2, 0)));
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
